// File: rtl/add_pipe_acc.sv
// add_pipe_acc: one-stage add/sub/accumulate datapath feeding a
// first-word-fall-through output FIFO with ready/valid on both sides.
module add_pipe_acc #(
  parameter int unsigned ADD_WIDTH  = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SATURATE   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADD_WIDTH-1:0]          a,
  input  logic [ADD_WIDTH-1:0]          b,
  input  logic                          cin,
  input  logic [1:0]                    mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADD_WIDTH-1:0]          sum,
  output logic                          cout,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned W  = ADD_WIDTH;
  localparam int unsigned RW = W + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = W + 2;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_n;
  logic [CW-1:0] count_n;
  logic [CW-1:0] remain;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_n;

  logic          push;
  logic          pop;
  logic [RW-1:0] raw;
  logic [W-1:0]  res_sum;
  logic          res_cout;
  logic          res_ovf;
  logic [EW-1:0] entry;
  logic [EW-1:0] head_n;
  logic          head_load;

  // Handshake: room in the FIFO, or a pop this cycle frees a slot.
  assign in_ready = rst && ((fifo_count < CW'(FIFO_DEPTH)) || out_ready);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Result of the presented beat, with optional saturation.
  always_comb begin
    raw      = '0;
    res_sum  = '0;
    res_cout = 1'b0;
    res_ovf  = 1'b0;
    acc_n    = acc;
    case (mode)
      MODE_ADD, MODE_ACC: begin
        if (mode == MODE_ACC) raw = {1'b0, acc} + {1'b0, a} + RW'(cin);
        else                  raw = {1'b0, a} + {1'b0, b} + RW'(cin);
        res_cout = raw[W];
        res_ovf  = raw[W];
        res_sum  = ((SATURATE != 0) && res_ovf) ? {W{1'b1}} : raw[W-1:0];
        if (mode == MODE_ACC) acc_n = res_sum;
      end
      MODE_SUB: begin
        raw      = {1'b0, a} - {1'b0, b} - RW'(cin);
        res_cout = ({1'b0, a} >= ({1'b0, b} + RW'(cin)));
        res_ovf  = ~res_cout;
        res_sum  = ((SATURATE != 0) && res_ovf) ? '0 : raw[W-1:0];
      end
      MODE_LOAD: begin
        res_sum = a;
        acc_n   = a;
      end
      default: ;
    endcase
  end

  assign entry = {res_sum, res_cout, res_ovf};

  // Next pointers, count and the entry that will sit at the head.
  always_comb begin
    rd_ptr_n  = rd_ptr + PW'(pop);
    count_n   = fifo_count + CW'(push) - CW'(pop);
    remain    = fifo_count - CW'(pop);
    head_n    = {sum, cout, ovf};
    head_load = 1'b0;
    if (remain != '0) begin
      head_n    = mem[rd_ptr_n];
      head_load = 1'b1;
    end else if (push) begin
      head_n    = entry;
      head_load = 1'b1;
    end
  end

  // FIFO storage; writes only on accepted beats, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // Pointers, count, accumulator and registered head outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      sum        <= '0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        acc    <= acc_n;
      end
      rd_ptr     <= rd_ptr_n;
      fifo_count <= count_n;
      out_valid  <= (count_n != '0);
      if (head_load) {sum, cout, ovf} <= head_n;
    end
  end

endmodule

// File: tb/tb_add_pipe_acc.sv
// Bench for add_pipe_acc: wrapping and saturating instances driven in
// parallel, compared each cycle against a queue-based reference model.
module tb_add_pipe_acc;

  localparam int W = 4;
  localparam int D = 4;
  localparam int M = 1 << W;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [W-1:0] a, b;
  logic cin;
  logic [1:0] mode;
  logic out_ready;

  logic in_ready0, in_ready1, out_valid0, out_valid1;
  logic [W-1:0] sum0, sum1;
  logic cout0, cout1, ovf0, ovf1;
  logic [$clog2(D):0] cnt0, cnt1;

  int tests = 0;
  int errs  = 0;

  res_t q [2][$];
  res_t last [2];
  int   acc_m [2];

  always #5 clk = ~clk;

  add_pipe_acc #(.ADD_WIDTH(W), .FIFO_DEPTH(D), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(out_valid0),
    .out_ready(out_ready), .sum(sum0), .cout(cout0), .ovf(ovf0),
    .fifo_count(cnt0));

  add_pipe_acc #(.ADD_WIDTH(W), .FIFO_DEPTH(D), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(out_valid1),
    .out_ready(out_ready), .sum(sum1), .cout(cout1), .ovf(ovf1),
    .fifo_count(cnt1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference arithmetic written directly from the unsigned rules.
  function automatic res_t calc(input int sat, input int md, input int av,
                                input int bv, input int ci, input int accv);
    res_t r;
    int t;
    r = '0;
    case (md)
      0, 2: begin
        t = (md == 2) ? accv + av + ci : av + bv + ci;
        r.c = (t >= M);
        r.o = r.c;
        r.s = (sat != 0 && r.o) ? W'(M - 1) : W'(t % M);
      end
      1: begin
        r.c = (av >= bv + ci);
        r.o = !r.c;
        t = av - bv - ci + 2 * M;
        r.s = (sat != 0 && r.o) ? '0 : W'(t % M);
      end
      default: r.s = W'(av);
    endcase
    return r;
  endfunction

  task automatic check_outputs(input int k, input logic ov, input logic [W-1:0] s,
                               input logic c, input logic o, input logic [31:0] cnt);
    res_t h;
    string p;
    p = (k == 0) ? "wrap" : "sat";
    check({p, ".out_valid"}, 32'(ov), 32'(q[k].size() > 0));
    check({p, ".fifo_count"}, cnt, 32'(q[k].size()));
    h = (q[k].size() > 0) ? q[k][0] : last[k];
    check({p, ".sum"}, 32'(s), 32'(h.s));
    check({p, ".cout"}, 32'(c), 32'(h.c));
    check({p, ".ovf"}, 32'(o), 32'(h.o));
  endtask

  // One clock: check ready, advance the model, then check the outputs.
  task automatic step();
    bit exp_ready, push, pop;
    res_t r;
    #1;
    exp_ready = rst && ((q[0].size() < D) || out_ready);
    check("wrap.in_ready", 32'(in_ready0), 32'(exp_ready));
    check("sat.in_ready", 32'(in_ready1), 32'(exp_ready));
    push = in_valid && exp_ready;
    pop  = (q[0].size() > 0) && out_ready;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        q[k].delete();
        last[k]  = '0;
        acc_m[k] = 0;
      end else begin
        if (pop) last[k] = q[k].pop_front();
        if (push) begin
          r = calc(k, int'(mode), int'(a), int'(b), int'(cin), acc_m[k]);
          q[k].push_back(r);
          if (mode == 2'b10) acc_m[k] = int'(r.s);
          if (mode == 2'b11) acc_m[k] = int'(a);
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs(0, out_valid0, sum0, cout0, ovf0, 32'(cnt0));
    check_outputs(1, out_valid1, sum1, cout1, ovf1, 32'(cnt1));
  endtask

  task automatic drive(input logic v, input int av, input int bv, input logic ci,
                       input logic [1:0] md, input logic ordy);
    in_valid  = v;
    a         = W'(av);
    b         = W'(bv);
    cin       = ci;
    mode      = md;
    out_ready = ordy;
    step();
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; mode = 2'b00; out_ready = 1'b0;
    foreach (last[k]) last[k] = '0;
    foreach (acc_m[k]) acc_m[k] = 0;

    // Reset held for two cycles, with a beat offered that must be ignored.
    drive(1, 3, 3, 0, 2'b00, 1);
    drive(1, 3, 3, 0, 2'b00, 1);
    rst = 1'b1;
    drive(0, 0, 0, 0, 2'b00, 1);

    // Add, sub, accumulate/load with an add in between.
    drive(1, 9, 8, 1, 2'b00, 1);
    drive(1, 3, 5, 0, 2'b01, 1);
    drive(1, 5, 5, 0, 2'b01, 1);
    drive(1, 7, 0, 0, 2'b11, 1);
    drive(1, 5, 0, 0, 2'b10, 1);
    drive(1, 1, 1, 0, 2'b00, 1);
    drive(1, 6, 0, 0, 2'b10, 1);
    drive(0, 0, 0, 0, 2'b00, 1);
    drive(0, 0, 0, 0, 2'b00, 1);

    // Fill with out_ready low, offer a fifth beat, then push/pop at full.
    for (int i = 0; i < D; i++) drive(1, i + 2, i, 1'(i), 2'b00, 0);
    drive(1, 15, 15, 1, 2'b00, 0);
    drive(1, 14, 1, 0, 2'b01, 1);
    for (int i = 0; i < D + 1; i++) drive(0, 0, 0, 0, 2'b00, 1);

    // Reset with three entries queued and acc=9, then accumulate from zero.
    drive(1, 9, 0, 0, 2'b11, 0);
    drive(1, 2, 3, 0, 2'b00, 0);
    drive(1, 4, 1, 0, 2'b01, 0);
    rst = 1'b0;
    drive(1, 8, 8, 1, 2'b10, 1);
    rst = 1'b1;
    drive(1, 1, 0, 0, 2'b10, 1);
    drive(0, 0, 0, 0, 2'b00, 1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, M - 1)),
            int'($urandom_range(0, M - 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 6));
    end
    rst = 1'b1;
    for (int i = 0; i < D + 2; i++) drive(0, 0, 0, 0, 2'b00, 1);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/add_pipe_acc.md
Name: add_pipe_acc

Overview:
Parametrised successor to the fixed 4-bit adder datapath: one registered add/subtract/accumulate stage feeding an output FIFO with ready/valid backpressure on both sides.
- Produces the same sum/cout result pair the add_out agent monitors, plus an overflow flag and an optional saturating mode.
- Sits between the add_in agent-driven operand bus and the add_out bus, so sum/cout map one-to-one onto add_out_if signals.

Parameters:
- ADD_WIDTH, 4, operand/sum width in bits (>=2).
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).
- SATURATE, 0, 1 = clamp out-of-range results (see Behaviour); 0 = wrap modulo 2^ADD_WIDTH.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept beat this cycle.
- a  input  ADD_WIDTH  operand A.
- b  input  ADD_WIDTH  operand B (ignored in modes 10/11).
- cin  input  1  carry-in (add/acc) or borrow-in (sub).
- mode  input  2  00 add, 01 sub, 10 accumulate, 11 load accumulator.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer takes head this cycle.
- sum  output  ADD_WIDTH  head result.
- cout  output  1  head carry (add/acc) or no-borrow (sub).
- ovf  output  1  head result out of unsigned range.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held.

Behaviour:
Reset
- Clock is clk; reset is synchronous and active-low on rst.
- rst=0 at a rising edge clears: FIFO pointers and count (fifo_count=0), accumulator to 0, out_valid=0, sum=0, cout=0, ovf=0.
- in_ready=0 while rst=0.
- Reset mid-operation discards all FIFO contents and the accumulator. No beat is accepted on the reset edge.

Handshake
- A beat is accepted when in_valid & in_ready at a rising edge.
- A head entry is popped when out_valid & out_ready.
- in_ready = (fifo_count < FIFO_DEPTH) | out_ready.
- Push and pop in the same cycle when full is legal: count stays at FIFO_DEPTH.
- Once out_valid=1, sum/cout/ovf stay stable until popped. in_valid may drop without penalty.

Latency
- Result computed combinationally from the accepted beat and written into the FIFO at the accepting edge.
- Appears on sum/cout/ovf with out_valid=1 one cycle later when the FIFO was empty (first-word fall-through).
- Results emerge in acceptance order.

Arithmetic (W = ADD_WIDTH; all operands unsigned)
- add: r = a + b + cin (W+1 bits); sum = r[W-1:0]; cout = r[W]; ovf = r[W].
- sub: r = a - b - cin; cout = 1 iff a >= b+cin; ovf = ~cout; sum = r mod 2^W.
- accumulate: r = acc + a + cin; sum/cout/ovf as add; acc <= sum on the accepting edge.
- load: sum = a, cout = 0, ovf = 0; acc <= a.
- Add and sub never modify acc.
- SATURATE=1: ovf in add/acc forces sum to all ones; ovf in sub forces sum to 0. cout/ovf still report raw flags. In accumulate, acc takes the saturated value.

Boundaries
- Empty with no push: out_valid=0, sum/cout/ovf hold last popped value.
- Full with out_ready=0: in_ready=0; acc unchanged until a beat is accepted.
- Pointers wrap modulo FIFO_DEPTH.
- mode sampled only on acceptance.

Test Plan:
1. W=4, reset: rst=0 for 2 cycles -> out_valid=0, in_ready=0, fifo_count=0, sum=0. After rst=1: in_ready=1.
2. Add, out_ready=1: a=9, b=8, cin=1 -> next cycle sum=2, cout=1, ovf=1. SATURATE=1 run: sum=15.
3. Sub: a=3, b=5, cin=0 -> sum=14, cout=0, ovf=1. SATURATE=1: sum=0. a=5, b=5 -> sum=0, cout=1, ovf=0.
4. Accumulate:
   - load a=7, then acc a=5 cin=0 -> sum=12, cout=0.
   - then acc a=6 -> sum=2, cout=1.
   - add between them leaves acc intact.
5. Backpressure, FIFO_DEPTH=4, out_ready=0:
   - push 4 beats -> fifo_count=4, in_ready=0.
   - raise out_ready with in_valid=1 -> count holds 4 for one cycle of simultaneous push/pop.
   - outputs drain in order.
6. Reset mid-stream with 3 entries queued and acc=9 -> next cycle fifo_count=0, out_valid=0. Then acc a=1 gives sum=1.
